// File: rtl/fp_mult_seq.sv
// fp_mult_seq: multicycle IEEE-754 single-precision multiplier.
// One operation at a time, started by a start pulse and finished with a done pulse.
// The significand product is built by a shift-add loop that runs for MBITS cycles.
// Build option: define FPMUL_ROUND_EN to get round-to-nearest-even.
// Without it the result is truncated (round toward zero).
// Handshake: in IDLE, start=1 captures op_a/op_b on the rising edge.
// busy is high from that edge until the edge that raises done.
// done is a single-cycle pulse that marks new resultado/especial values.
// start is ignored while busy, and also during the done cycle.
module fp_mult_seq #(
   parameter int MBITS = 24
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   output logic        busy,
   output logic        done,
   output logic [31:0] resultado,
   output logic [1:0]  especial
);

   localparam int CW = $clog2(MBITS + 1);

   typedef enum logic [2:0] {IDLE, UNPACK, MULT, NORM, ROUND, DONE} state_t;

   state_t              state;
   logic [31:0]         a_q, b_q;
   logic                sign_q;
   logic signed [9:0]   exp_sum;
   logic [47:0]         mcand, prod;
   logic [23:0]         mplier;
   logic [CW-1:0]       cnt;
   logic [23:0]         sig_q;
   logic                guard_q, sticky_q;
   logic [31:0]         res_q;
   logic [1:0]          esp_q;

   // Operand classification used by UNPACK; denormals count as zero
   logic [7:0]          ea, eb;
   logic [22:0]         fa, fb;
   logic                a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sign_ab;
   logic signed [9:0]   exp_init;

   // Decode fields and special classes of the captured operands
   always_comb begin
      ea       = a_q[30:23];
      eb       = b_q[30:23];
      fa       = a_q[22:0];
      fb       = b_q[22:0];
      sign_ab  = a_q[31] ^ b_q[31];
      a_zero   = (ea == 8'h00);
      b_zero   = (eb == 8'h00);
      a_inf    = (ea == 8'hFF) && (fa == 23'd0);
      b_inf    = (eb == 8'hFF) && (fb == 23'd0);
      a_nan    = (ea == 8'hFF) && (fa != 23'd0);
      b_nan    = (eb == 8'hFF) && (fb != 23'd0);
      exp_init = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
   end

   // Rounded significand and exponent, then overflow/underflow packing
   logic [23:0]         sig_r;
   logic signed [9:0]   exp_r;
   logic [31:0]         pack_res;
   logic [1:0]          pack_esp;
`ifdef FPMUL_ROUND_EN
   logic                round_up;
   logic [24:0]         sig_sum;
`else
   logic                unused_rnd;
`endif

   // Round (or truncate), then classify the final exponent
   always_comb begin
`ifdef FPMUL_ROUND_EN
      round_up = guard_q & (sticky_q | sig_q[0]);
      sig_sum  = {1'b0, sig_q} + {24'd0, round_up};
      if (sig_sum[24]) begin
         // 1.111..1 rounded up becomes 10.0: renormalise to 1.0
         sig_r = 24'h800000;
         exp_r = exp_sum + 10'sd1;
      end else begin
         sig_r = sig_sum[23:0];
         exp_r = exp_sum;
      end
`else
      unused_rnd = guard_q ^ sticky_q;
      sig_r      = sig_q;
      exp_r      = exp_sum;
`endif
      if (exp_r >= 10'sd255) begin
         pack_res = {sign_q, 8'hFF, 23'd0};
         pack_esp = 2'b01;
      end else if (exp_r <= 10'sd0) begin
         pack_res = {sign_q, 31'd0};
         pack_esp = 2'b00;
      end else begin
         pack_res = {sign_q, exp_r[7:0], sig_r[22:0]};
         pack_esp = 2'b00;
      end
   end

   // Control FSM and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         resultado <= 32'd0;
         especial  <= 2'b00;
         a_q       <= 32'd0;
         b_q       <= 32'd0;
         sign_q    <= 1'b0;
         exp_sum   <= 10'sd0;
         mcand     <= 48'd0;
         mplier    <= 24'd0;
         prod      <= 48'd0;
         cnt       <= '0;
         sig_q     <= 24'd0;
         guard_q   <= 1'b0;
         sticky_q  <= 1'b0;
         res_q     <= 32'd0;
         esp_q     <= 2'b00;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start && !done) begin
                  a_q   <= op_a;
                  b_q   <= op_b;
                  busy  <= 1'b1;
                  state <= UNPACK;
               end
            end
            UNPACK: begin
               sign_q <= sign_ab;
               if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
                  res_q <= 32'h7FC00000;
                  esp_q <= 2'b11;
                  state <= DONE;
               end else if (a_inf || b_inf) begin
                  res_q <= {sign_ab, 8'hFF, 23'd0};
                  esp_q <= 2'b01;
                  state <= DONE;
               end else if (a_zero || b_zero) begin
                  res_q <= {sign_ab, 31'd0};
                  esp_q <= 2'b00;
                  state <= DONE;
               end else begin
                  mcand   <= {24'd0, 1'b1, fa};
                  mplier  <= {1'b1, fb};
                  prod    <= 48'd0;
                  cnt     <= '0;
                  exp_sum <= exp_init;
                  state   <= MULT;
               end
            end
            MULT: begin
               if (mplier[0]) prod <= prod + mcand;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + 1'b1;
               if (cnt == CW'(MBITS - 1)) state <= NORM;
            end
            NORM: begin
               // Product of two [1,2) significands lies in [1,4)
               if (prod[47]) begin
                  sig_q    <= prod[47:24];
                  guard_q  <= prod[23];
                  sticky_q <= |prod[22:0];
                  exp_sum  <= exp_sum + 10'sd1;
               end else begin
                  sig_q    <= prod[46:23];
                  guard_q  <= prod[22];
                  sticky_q <= |prod[21:0];
               end
               state <= ROUND;
            end
            ROUND: begin
               res_q <= pack_res;
               esp_q <= pack_esp;
               state <= DONE;
            end
            DONE: begin
               resultado <= res_q;
               especial  <= esp_q;
               done      <= 1'b1;
               busy      <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_mult_seq.sv
// tb_fp_mult_seq: directed vector table plus hand-written multicycle sequences.
module tb_fp_mult_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] op_a = 32'd0;
   logic [31:0] op_b = 32'd0;
   logic        busy, done;
   logic [31:0] resultado;
   logic [1:0]  especial;

   int checks = 0;
   int failures = 0;
   logic [31:0] exp_q[$];

   fp_mult_seq #(.MBITS(24)) dut (
      .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
      .busy(busy), .done(done), .resultado(resultado), .especial(especial)
   );

   // clock / reset
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [1:0]  esp;
      int          lat;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
      checks++;
      if (got !== expv) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, got, expv);
      end
   endtask

   // driver: issue one operation and wait (bounded) for its done pulse
   task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic [1:0] e,
                        output int lat, output bit busy_ok, output bit pulse_ok);
      @(negedge clk);
      op_a  = a;
      op_b  = b;
      start = 1'b1;
      @(posedge clk);
      #1;
      start   = 1'b0;
      op_a    = $urandom;
      op_b    = $urandom;
      busy_ok = busy;
      lat     = 0;
      while (lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
         if (done) break;
         if (!busy) busy_ok = 1'b0;
      end
      if (busy) busy_ok = 1'b0;
      r = resultado;
      e = especial;
      @(posedge clk);
      #1;
      pulse_ok = !done;
   endtask

   initial begin
      logic [31:0] r;
      logic [1:0]  e;
      int          lat, n_done, first_lat;
      bit          busy_ok, pulse_ok;
      logic [31:0] first_res;

      vecs[0]  = '{"two_x_three",   32'h40000000, 32'h40400000, 32'h40C00000, 2'b00, 28};
`ifdef FPMUL_ROUND_EN
      vecs[1]  = '{"round_case",    32'h3FC00001, 32'h3FC00001, 32'h40100002, 2'b00, 28};
`else
      vecs[1]  = '{"round_case",    32'h3FC00001, 32'h3FC00001, 32'h40100001, 2'b00, 28};
`endif
      vecs[2]  = '{"inf_x_two",     32'h7F800000, 32'h40000000, 32'h7F800000, 2'b01, 2};
      vecs[3]  = '{"inf_x_zero",    32'h7F800000, 32'h00000000, 32'h7FC00000, 2'b11, 2};
      vecs[4]  = '{"overflow",      32'h7F000000, 32'h7F000000, 32'h7F800000, 2'b01, 28};
      vecs[5]  = '{"underflow",     32'h00800000, 32'h00800000, 32'h00000000, 2'b00, 28};
      vecs[6]  = '{"neg_two_x_3",   32'hC0000000, 32'h40400000, 32'hC0C00000, 2'b00, 28};
      vecs[7]  = '{"one_x_one",     32'h3F800000, 32'h3F800000, 32'h3F800000, 2'b00, 28};
      vecs[8]  = '{"onep5_sq",      32'h3FC00000, 32'h3FC00000, 32'h40100000, 2'b00, 28};
      vecs[9]  = '{"one_ulp_sq",    32'h3F800001, 32'h3F800001, 32'h3F800002, 2'b00, 28};
      vecs[10] = '{"nan_x_one",     32'h7FC12345, 32'h3F800000, 32'h7FC00000, 2'b11, 2};
      vecs[11] = '{"zero_x_neg5",   32'h00000000, 32'hC0A00000, 32'h80000000, 2'b00, 2};
      vecs[12] = '{"denorm_x_two",  32'h00000001, 32'h40000000, 32'h00000000, 2'b00, 2};
      vecs[13] = '{"ninf_x_ninf",   32'hFF800000, 32'hFF800000, 32'h7F800000, 2'b01, 2};

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_res", resultado, 32'd0);
      check("rst_esp", {30'd0, especial}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // vector table
      foreach (vecs[i]) begin
         exp_q.push_back(vecs[i].res);
         do_op(vecs[i].a, vecs[i].b, r, e, lat, busy_ok, pulse_ok);
         check({vecs[i].name, "_res"}, r, exp_q.pop_front());
         check({vecs[i].name, "_esp"}, {30'd0, e}, {30'd0, vecs[i].esp});
         check({vecs[i].name, "_lat"}, lat, vecs[i].lat);
         check({vecs[i].name, "_busy"}, {31'd0, busy_ok}, 32'd1);
         check({vecs[i].name, "_pulse"}, {31'd0, pulse_ok}, 32'd1);
      end

      // start pulsed again during MULT must be ignored
      @(negedge clk);
      op_a = 32'h40000000; op_b = 32'h40400000; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      n_done = 0; first_lat = 0; first_res = 32'd0;
      for (int k = 1; k <= 70; k++) begin
         @(posedge clk);
         #1;
         if (k == 6) begin
            op_a = 32'h3F800000; op_b = 32'h3F800000; start = 1'b1;
         end
         if (k == 7) start = 1'b0;
         if (done) begin
            n_done++;
            if (n_done == 1) begin
               first_lat = k;
               first_res = resultado;
            end
         end
      end
      check("ignore_start_ndone", n_done, 1);
      check("ignore_start_lat", first_lat, 28);
      check("ignore_start_res", first_res, 32'h40C00000);

      // reset during MULT aborts without a done
      @(negedge clk);
      op_a = 32'h40000000; op_b = 32'h40400000; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (11) @(posedge clk);
      #1;
      check("pre_rst_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_res", resultado, 32'd0);
      check("abort_esp", {30'd0, especial}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      n_done = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done) n_done++;
      end
      check("abort_no_done", n_done, 0);
      do_op(32'hC0000000, 32'h40400000, r, e, lat, busy_ok, pulse_ok);
      check("after_abort_res", r, 32'hC0C00000);
      check("after_abort_lat", lat, 28);
      check("after_abort_busy", {31'd0, busy_ok}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
